// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache arbiter onto a single-ported RAM
// dcache wins by default; a streak counter forces the icache in after STARVE_LIMIT dcache grants.
module cache_mem_arbiter #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ramerr
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  localparam logic [1:0] RAM_ERROR = 2'd3;

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          done;
  logic          dreq;
  logic          force_i;

  // ACCESS (2) and ERROR (3) both end the transaction
  assign done    = ramstate[1];
  assign dreq    = dREN | dWEN;
  assign force_i = (STARVE_LIMIT != 0) && iREN && (streak == LIM);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      streak <= '0;
      ramerr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !force_i) begin
            state <= DACC;
          end else if (iREN) begin
            state  <= IACC;
            streak <= '0;
          end
        end
        IACC: begin
          if (done) begin
            state <= IDLE;
            if (ramstate == RAM_ERROR) ramerr <= 1'b1;
          end else if (!iREN) begin
            state <= IDLE;
          end
        end
        DACC: begin
          if (done) begin
            state <= IDLE;
            if (ramstate == RAM_ERROR) ramerr <= 1'b1;
            if (!iREN)              streak <= '0;
            else if (streak != LIM) streak <= streak + 1'b1;
          end else if (!dreq) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM side is a pure decode of the grant; a simultaneous dREN/dWEN is a write
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DACC: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  assign iwait = !((state == IACC) && done);
  assign dwait = !((state == DACC) && done);
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - bench for cache_mem_arbiter
// Vector table, directed grant-order/abort/reset sequences, then random traffic vs a transaction model.
module tb_cache_mem_arbiter;

  localparam int LIMIT = 2;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, ramerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_cmp = 0;
  int n_bad = 0;

  cache_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iren, dren, dwen;
    logic [31:0] iaddr, daddr, dstore, rload;
    logic [1:0]  rs;
    logic        e_ren, e_wen, e_iw, e_dw, e_err;
    logic [31:0] e_addr, e_store;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                     input logic [31:0] rl, input logic er, input logic ew,
                     input logic [31:0] ea, input logic [31:0] es,
                     input logic eiw, input logic edw, input logic eer);
    vec_t v;
    v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw; v.daddr = da; v.dstore = ds;
    v.rs = rs; v.rload = rl; v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es;
    v.e_iw = eiw; v.e_dw = edw; v.e_err = eer;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = 2'd0;
  endtask

  // Both caches request continuously with RAM ACCESS every cycle; record who is granted.
  task automatic collect(input int n, input logic [31:0] ia, input logic [31:0] da,
                         output string order);
    int got = 0;
    order = "";
    iREN = 1; dREN = 1; dWEN = 0; iaddr = ia; daddr = da; ramstate = 2'd2;
    for (int c = 0; c < 4 * n && got < n; c++) begin
      settle();
      if (ramREN) begin
        order = {order, (ramaddr == ia) ? "I" : "D"};
        got++;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // Transaction-level reference: who currently owns the RAM, how many dcache wins in a row.
  int          m_owner;  // 0 nobody, 1 icache, 2 dcache
  int          m_streak;
  logic        m_err;

  string order;

  initial begin
    idle_inputs();
    RST = 1;
    tick(); tick();
    RST = 0;

    settle();
    chk("reset_ramREN", ramREN, 0);
    chk("reset_ramWEN", ramWEN, 0);
    chk("reset_ramaddr", ramaddr, 0);
    chk("reset_ramerr", ramerr, 0);
    tick();

    // icache read with two BUSY cycles
    add(1,'h100,0,0,0,0,0,0,            0,0,0,0,          1,1,0);
    add(1,'h100,0,0,0,0,1,0,            1,0,'h100,0,      1,1,0);
    add(1,'h100,0,0,0,0,1,0,            1,0,'h100,0,      1,1,0);
    add(1,'h100,0,0,0,0,2,'hDEADBEEF,   1,0,'h100,0,      0,1,0);
    add(0,0,0,0,0,0,0,0,                0,0,0,0,          1,1,0);
    // simultaneous icache read and dcache write: dcache first, icache after one IDLE
    add(1,'h100,0,1,'h200,'h1234,0,0,   0,0,0,0,          1,1,0);
    add(1,'h100,0,1,'h200,'h1234,1,0,   0,1,'h200,'h1234, 1,1,0);
    add(1,'h100,0,1,'h200,'h1234,2,'hBAD, 0,1,'h200,'h1234, 1,0,0);
    add(1,'h100,0,0,0,0,0,0,            0,0,0,0,          1,1,0);
    add(1,'h100,0,0,0,0,2,'hCAFE,       1,0,'h100,0,      0,1,0);
    add(0,0,0,0,0,0,0,0,                0,0,0,0,          1,1,0);
    // ERROR on an icache read is sticky across a later dcache read
    add(1,'h40,0,0,0,0,0,0,             0,0,0,0,          1,1,0);
    add(1,'h40,0,0,0,0,3,'h77,          1,0,'h40,0,       0,1,0);
    add(0,0,0,0,0,0,0,0,                0,0,0,0,          1,1,1);
    add(0,0,1,0,'h80,0,0,0,             0,0,0,0,          1,1,1);
    add(0,0,1,0,'h80,0,2,'h55,          1,0,'h80,0,       1,0,1);
    add(0,0,0,0,0,0,2,0,                0,0,0,0,          1,1,1);

    foreach (vq[k]) begin
      iREN = vq[k].iren; iaddr = vq[k].iaddr; dREN = vq[k].dren; dWEN = vq[k].dwen;
      daddr = vq[k].daddr; dstore = vq[k].dstore; ramstate = vq[k].rs; ramload = vq[k].rload;
      settle();
      chk($sformatf("v%0d_ramREN", k), ramREN, vq[k].e_ren);
      chk($sformatf("v%0d_ramWEN", k), ramWEN, vq[k].e_wen);
      chk($sformatf("v%0d_ramaddr", k), ramaddr, vq[k].e_addr);
      chk($sformatf("v%0d_ramstore", k), ramstore, vq[k].e_store);
      chk($sformatf("v%0d_iwait", k), iwait, vq[k].e_iw);
      chk($sformatf("v%0d_dwait", k), dwait, vq[k].e_dw);
      chk($sformatf("v%0d_ramerr", k), ramerr, vq[k].e_err);
      if (!vq[k].e_iw) chk($sformatf("v%0d_iload", k), iload, vq[k].rload);
      if (!vq[k].e_dw) chk($sformatf("v%0d_dload", k), dload, vq[k].rload);
      tick();
    end
    idle_inputs();
    tick();

    // starvation bound
    collect(6, 32'h111, 32'h222, order);
    n_cmp++;
    if (order != "DDIDDI") begin
      n_bad++;
      $display("FAIL grant_order: got %s expected DDIDDI", order);
    end

    // dcache abort while BUSY, then a normal icache grant
    dREN = 1; daddr = 'h300;
    settle(); tick();
    ramstate = 2'd1;
    settle();
    chk("abort_grant_ren", ramREN, 1);
    tick();
    dREN = 0;
    settle();
    chk("abort_dwait", dwait, 1);
    tick();
    iREN = 1; iaddr = 'h400; ramstate = 2'd1;
    settle();
    chk("abort_idle_ren", ramREN, 0);
    chk("abort_idle_addr", ramaddr, 0);
    tick();
    ramstate = 2'd2; ramload = 'h4444;
    settle();
    chk("after_abort_ren", ramREN, 1);
    chk("after_abort_addr", ramaddr, 'h400);
    chk("after_abort_iwait", iwait, 0);
    tick();
    idle_inputs();
    tick();

    // reset mid-DACC with streak=1 (ramerr still set from the ERROR above)
    iREN = 1; dREN = 1; iaddr = 'h111; daddr = 'h222; ramstate = 2'd2;
    settle(); tick();
    settle(); tick();
    ramstate = 2'd0;
    settle(); tick();
    ramstate = 2'd1;
    settle();
    chk("rst_pre_ren", ramREN, 1);
    chk("rst_pre_addr", ramaddr, 'h222);
    RST = 1;
    tick();
    RST = 0;
    settle();
    chk("rst_ren", ramREN, 0);
    chk("rst_wen", ramWEN, 0);
    chk("rst_err", ramerr, 0);
    tick();
    collect(3, 32'h111, 32'h222, order);
    n_cmp++;
    if (order != "DDI") begin
      n_bad++;
      $display("FAIL rst_streak_order: got %s expected DDI", order);
    end

    // random traffic against the reference
    RST = 1;
    tick();
    RST = 0;
    m_owner = 0; m_streak = 0; m_err = 0;
    for (int c = 0; c < 400; c++) begin
      int r;
      logic        e_ren, e_wen, e_iw, e_dw, fin, want_d;
      logic [31:0] e_addr, e_store;
      iREN = ($urandom_range(0, 3) != 0);
      dREN = ($urandom_range(0, 2) == 0);
      dWEN = ($urandom_range(0, 3) == 0);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      r = $urandom_range(0, 9);
      ramstate = (r < 4) ? 2'(r % 2) : (r < 9) ? 2'd2 : 2'd3;
      fin = (ramstate >= 2);

      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
      if (m_owner == 1) begin
        e_ren = 1; e_addr = iaddr;
      end else if (m_owner == 2) begin
        e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
      end
      e_iw = !(m_owner == 1 && fin);
      e_dw = !(m_owner == 2 && fin);

      settle();
      chk($sformatf("rnd%0d_ctl", c), {ramREN, ramWEN, iwait, dwait, ramerr},
          {e_ren, e_wen, e_iw, e_dw, m_err});
      chk($sformatf("rnd%0d_addr", c), ramaddr, e_addr);
      chk($sformatf("rnd%0d_store", c), ramstore, e_store);

      want_d = dREN || dWEN;
      if (m_owner == 0) begin
        if (want_d && !(LIMIT != 0 && iREN && m_streak == LIMIT)) begin
          m_owner = 2;
        end else if (iREN) begin
          m_owner = 1; m_streak = 0;
        end
      end else if (fin) begin
        if (ramstate == 2'd3) m_err = 1;
        if (m_owner == 2) m_streak = iREN ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
        m_owner = 0;
      end else if ((m_owner == 1 && !iREN) || (m_owner == 2 && !want_d)) begin
        m_owner = 0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
